// File: rtl/bt_seq_pkg.sv
// Shared types for the Bluetooth command sequencer: FSM states and the
// {start,len} command descriptor handed to the UART sender.
package bt_seq_pkg;

    localparam int CMD_AW_DEF = 5;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [2:0] {
        PWRUP,
        PROMPT,
        INIT_SEND,
        INIT_WAIT,
        IDLE,
        CMD_WAIT
    } state_t;

    // Sized for the default ROM geometry; the top casts to its own port widths.
    typedef struct packed {
        logic [CMD_AW_DEF-1:0] start;
        logic [LEN_W_DEF-1:0]  len;
    } cmd_t;

endpackage

// File: rtl/bt_req_arb.sv
// Per-button pending latches with a round-robin grant. A new request in the
// same cycle as the grant ack of that button keeps the latch set.
module bt_req_arb #(
    parameter int NUM_BTN = 2,
    parameter int IW      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] i_req,
    input  logic               i_ack,
    output logic [IW-1:0]      o_gnt_idx,
    output logic               o_gnt_vld
);

    logic [NUM_BTN-1:0] r_pend;
    logic [IW-1:0]      r_rr;
    logic [NUM_BTN-1:0] w_clr;

    // Walk from the highest offset down so the closest pending button to r_rr wins.
    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_idx = '0;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            if (r_pend[(int'(r_rr) + k) % NUM_BTN]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = IW'((int'(r_rr) + k) % NUM_BTN);
            end
        end
    end

    assign w_clr = (i_ack && o_gnt_vld) ? (NUM_BTN'(1) << o_gnt_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_rr   <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | i_req;
            if (i_ack && o_gnt_vld)
                r_rr <= (int'(o_gnt_idx) == NUM_BTN - 1) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bt_cmd_sequencer.sv
// BT module front end: power-up hold, prompt wait, init command replay, then
// single-outstanding button commands with timeout, bounded retry and error pulse.
module bt_cmd_sequencer
    import bt_seq_pkg::*;
#(
    parameter int NUM_BTN     = 2,
    parameter int CMD_AW      = CMD_AW_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int PWRUP_CYC   = 131072,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int MAX_RETRY   = 2,
    parameter int INIT_CNT    = 2,
    parameter logic [INIT_CNT*CMD_AW-1:0] INIT_START = {5'd6, 5'd0},
    parameter logic [INIT_CNT*LEN_W-1:0]  INIT_LEN   = {4'd10, 4'd6},
    parameter int BTN_BASE    = 16,
    parameter int BTN_LEN     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_rel,
    input  logic               resp_rcvd,
    output logic               cmd_n,
    output logic               send,
    output logic [CMD_AW-1:0]  cmd_start,
    output logic [LEN_W-1:0]   cmd_len,
    output logic               ready,
    output logic               busy,
    output logic               err
);

    localparam int IW  = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int PW  = $clog2(PWRUP_CYC + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam int RW  = $clog2(MAX_RETRY + 2);
    localparam int IXW = (INIT_CNT > 1) ? $clog2(INIT_CNT) : 1;

    state_t         r_state;
    logic [PW-1:0]  r_pwr_cnt;
    logic [TW-1:0]  r_tmo_cnt;
    logic [RW-1:0]  r_retry;
    logic [IXW-1:0] r_idx;
    cmd_t           r_cmd;
    logic           r_cmd_n, r_send, r_ready, r_busy, r_err;

    logic [IW-1:0]  w_gnt_idx;
    logic           w_gnt_vld;
    logic           w_ack;
    logic           w_tmo;
    logic           w_can_retry;
    cmd_t           w_init_cmd;
    cmd_t           w_btn_cmd;

    assign w_ack       = (r_state == IDLE) && w_gnt_vld;
    assign w_tmo       = (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_can_retry = (r_retry < RW'(MAX_RETRY));

    always_comb begin
        w_init_cmd.start = CMD_AW_DEF'(INIT_START[int'(r_idx)*CMD_AW +: CMD_AW]);
        w_init_cmd.len   = LEN_W_DEF'(INIT_LEN[int'(r_idx)*LEN_W +: LEN_W]);
        w_btn_cmd.start  = CMD_AW_DEF'(BTN_BASE + int'(w_gnt_idx) * BTN_LEN);
        w_btn_cmd.len    = LEN_W_DEF'(BTN_LEN);
    end

    bt_req_arb #(
        .NUM_BTN (NUM_BTN),
        .IW      (IW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (btn_rel),
        .i_ack     (w_ack),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= PWRUP;
            r_pwr_cnt <= '0;
            r_tmo_cnt <= '0;
            r_retry   <= '0;
            r_idx     <= '0;
            r_cmd     <= '0;
            r_cmd_n   <= 1'b1;
            r_send    <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_send <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                PWRUP: begin
                    if (r_pwr_cnt == PW'(PWRUP_CYC - 1)) begin
                        r_cmd_n   <= 1'b0;
                        r_tmo_cnt <= '0;
                        r_state   <= PROMPT;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 1'b1;
                    end
                end
                PROMPT: begin
                    if (resp_rcvd) begin
                        r_idx   <= '0;
                        r_state <= INIT_SEND;
                    end else if (w_tmo) begin
                        r_err     <= 1'b1;
                        r_cmd_n   <= 1'b1;
                        r_pwr_cnt <= '0;
                        r_state   <= PWRUP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                INIT_SEND: begin
                    r_send    <= 1'b1;
                    r_cmd     <= w_init_cmd;
                    r_busy    <= 1'b1;
                    r_retry   <= '0;
                    r_tmo_cnt <= '0;
                    r_state   <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    if (resp_rcvd) begin
                        r_busy <= 1'b0;
                        if (int'(r_idx) == INIT_CNT - 1) begin
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= INIT_SEND;
                        end
                    end else if (w_tmo) begin
                        if (w_can_retry) begin
                            // Resend straight from here; r_cmd still holds the entry.
                            r_retry   <= r_retry + 1'b1;
                            r_send    <= 1'b1;
                            r_tmo_cnt <= '0;
                        end else begin
                            r_err     <= 1'b1;
                            r_busy    <= 1'b0;
                            r_cmd_n   <= 1'b1;
                            r_pwr_cnt <= '0;
                            r_state   <= PWRUP;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_send    <= 1'b1;
                        r_cmd     <= w_btn_cmd;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_retry   <= '0;
                        r_tmo_cnt <= '0;
                        r_state   <= CMD_WAIT;
                    end
                end
                CMD_WAIT: begin
                    if (resp_rcvd) begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_tmo) begin
                        if (w_can_retry) begin
                            r_retry   <= r_retry + 1'b1;
                            r_send    <= 1'b1;
                            r_tmo_cnt <= '0;
                        end else begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: r_state <= PWRUP;
            endcase
        end
    end

    assign cmd_n     = r_cmd_n;
    assign send      = r_send;
    assign cmd_start = CMD_AW'(r_cmd.start);
    assign cmd_len   = LEN_W'(r_cmd.len);
    assign ready     = r_ready;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_bt_cmd_sequencer.sv
// Scoreboard bench: expected {start,len} pushed with stimulus, popped on each send.
module tb_bt_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_rel;
    logic       resp_rcvd;
    logic       cmd_n, send, ready, busy, err;
    logic [4:0] cmd_start;
    logic [3:0] cmd_len;

    int n_chk = 0;
    int n_err = 0;
    int n_send = 0;
    logic [8:0] sb_q[$];

    bt_cmd_sequencer #(
        .PWRUP_CYC   (16),
        .TIMEOUT_CYC (64),
        .MAX_RETRY   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_rel   (btn_rel),
        .resp_rcvd (resp_rcvd),
        .cmd_n     (cmd_n),
        .send      (send),
        .cmd_start (cmd_start),
        .cmd_len   (cmd_len),
        .ready     (ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst && send) begin
            n_send++;
            if (sb_q.size() == 0) chk("sb_unexpected_send", 32'(sb_q.size()), 32'd1);
            else chk("sb_cmd", 32'({cmd_start, cmd_len}), 32'(sb_q.pop_front()));
        end
    end

    task automatic push(input logic [4:0] s, input logic [3:0] l);
        sb_q.push_back({s, l});
    endtask

    task automatic pulse_resp();
        resp_rcvd = 1'b1;
        @(negedge clk);
        resp_rcvd = 1'b0;
    endtask

    task automatic press(input logic [1:0] b);
        btn_rel = b;
        @(negedge clk);
        btn_rel = 2'b00;
    endtask

    task automatic wait_hi(input int sel, input int bound, output int n);
        logic hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < bound) begin
            @(negedge clk);
            n++;
            hit = (sel == 0) ? send : err;
        end
        if (!hit) chk("wait_bound", 32'(hit), 32'd1);
    endtask

    task automatic wait_pwrup(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (cmd_n && k < 100);
        chk(tag, 32'(k), 32'd16);
    endtask

    task automatic do_init();
        int n;
        push(5'd0, 4'd6);
        push(5'd6, 4'd10);
        pulse_resp();
        wait_hi(0, 20, n);
        chk("init0_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        pulse_resp();
        wait_hi(0, 20, n);
        chk("init1_ready", 32'(ready), 32'd0);
        repeat (3) @(negedge clk);
        pulse_resp();
        repeat (2) @(negedge clk);
        chk("init_done_ready", 32'(ready), 32'd1);
        chk("init_done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n, s0;
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s0;
        rst = 1'b1;
        btn_rel = 2'b00;
        resp_rcvd = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_n", 32'(cmd_n), 32'd1);
        chk("rst_send", 32'(send), 32'd0);
        chk("rst_cmd", 32'({cmd_start, cmd_len}), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // power-up hold, then silence until the prompt arrives
        wait_pwrup("pwrup_len");
        repeat (5) @(negedge clk);
        chk("no_send_before_prompt", 32'(n_send), 32'd0);

        do_init();

        // both buttons at once: button 0 first, then 1; second pair wraps to 0
        for (int r = 0; r < 2; r++) begin
            push(5'd16, 4'd4);
            push(5'd20, 4'd4);
            press(2'b11);
            wait_hi(0, 20, n);
            chk("btn_latency", 32'(n + 1), 32'd2);
            chk("cmd_wait_busy", 32'(busy), 32'd1);
            chk("cmd_wait_ready", 32'(ready), 32'd0);
            repeat (3) @(negedge clk);
            pulse_resp();
            wait_hi(0, 20, n);
            repeat (3) @(negedge clk);
            pulse_resp();
            repeat (2) @(negedge clk);
            chk("pair_done_ready", 32'(ready), 32'd1);
        end

        // button timeout: one resend at +64, abandon at +128
        push(5'd16, 4'd4);
        push(5'd16, 4'd4);
        press(2'b01);
        wait_hi(0, 20, n);
        wait_hi(0, 100, n);
        chk("resend_gap", 32'(n), 32'd64);
        wait_hi(1, 100, n);
        chk("abandon_gap", 32'(n), 32'd64);
        chk("abandon_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("err_one_cycle", 32'(err), 32'd0);
        chk("abandon_ready", 32'(ready), 32'd1);

        // repeat press during CMD_WAIT and in the grant cycle -> exactly two button-0 commands
        s0 = n_send;
        push(5'd20, 4'd4);
        push(5'd16, 4'd4);
        push(5'd16, 4'd4);
        press(2'b10);
        wait_hi(0, 20, n);
        repeat (3) @(negedge clk);
        press(2'b01);
        repeat (2) @(negedge clk);
        pulse_resp();
        press(2'b01);
        chk("grant_cycle_send", 32'(send), 32'd1);
        repeat (3) @(negedge clk);
        pulse_resp();
        wait_hi(0, 20, n);
        repeat (3) @(negedge clk);
        pulse_resp();
        repeat (30) @(negedge clk);
        chk("coalesce_count", 32'(n_send - s0), 32'd3);

        // init timeout exhausted -> full restart through PWRUP
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_pwrup("pwrup_len_2");
        push(5'd0, 4'd6);
        push(5'd0, 4'd6);
        pulse_resp();
        wait_hi(0, 20, n);
        wait_hi(0, 100, n);
        chk("init_resend_gap", 32'(n), 32'd64);
        wait_hi(1, 100, n);
        chk("init_abandon_gap", 32'(n), 32'd64);
        chk("init_abandon_cmd_n", 32'(cmd_n), 32'd1);
        wait_pwrup("restart_pwrup");
        do_init();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bt_cmd_sequencer.md
Name: bt_cmd_sequencer

Overview:
Parametrised successor to the audio player's Bluetooth command front end. It holds the BT module in power-up, waits for the module's prompt, then replays a parameter-defined init command list. After init it arbitrates NUM_BTN button-release requests into single-outstanding commands for the external snd_cmd UART sender. Adds per-button pending latches, round-robin arbitration, response timeout, bounded retry and an error flag.

Parameters:
NUM_BTN, 2, number of button request channels (1..8)
CMD_AW, 5, command ROM address width (cmd_start)
LEN_W, 4, command length width (cmd_len)
PWRUP_CYC, 131072, cycles cmd_n held high after reset
TIMEOUT_CYC, 1000000, cycles allowed from send (or prompt wait start) to resp_rcvd
MAX_RETRY, 2, resends after a timeout before the command is abandoned
INIT_CNT, 2, number of init commands (1..8)
INIT_START, {5'd6,5'd0}, packed INIT_CNT x CMD_AW start addresses, entry 0 in LSBs
INIT_LEN, {4'd10,4'd6}, packed INIT_CNT x LEN_W lengths
BTN_BASE, 16, ROM address of button 0 command
BTN_LEN, 4, length of each button command; button i start = BTN_BASE + i*BTN_LEN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
btn_rel  in  NUM_BTN  one-cycle release pulses (from PB_release instances)
resp_rcvd  in  1  one-cycle pulse from snd_cmd: response received
cmd_n  out  1  BT module command-mode pin; high = held off
send  out  1  one-cycle pulse: start sending cmd_start/cmd_len
cmd_start  out  CMD_AW  ROM start address of current command
cmd_len  out  LEN_W  length of current command
ready  out  1  init complete, no command outstanding
busy  out  1  command outstanding (between send and its response/abandon)
err  out  1  one-cycle pulse: command abandoned or prompt timeout

Behaviour:
- Reset: state PWRUP, cmd_n=1, send=0, cmd_start=0, cmd_len=0, ready=0, busy=0, err=0, pending=0, rr pointer=0, counters=0.
- All outputs registered. cmd_start/cmd_len update in the same cycle send rises and hold until the next send.
- PWRUP: cmd_n=1; count PWRUP_CYC cycles, then cmd_n=0 -> PROMPT.
- PROMPT: wait for resp_rcvd (module prompt). On resp_rcvd -> INIT_SEND, idx=0. If TIMEOUT_CYC elapses first: err pulse, -> PWRUP (cmd_n returns to 1).
- INIT_SEND: send pulse with INIT_START[idx]/INIT_LEN[idx], retry=0 -> INIT_WAIT (busy=1).
- INIT_WAIT: on resp_rcvd, idx++; if idx==INIT_CNT -> IDLE, else -> INIT_SEND. On timeout: if retry<MAX_RETRY, retry++ and resend same entry; else err pulse, -> PWRUP (full restart).
- IDLE: ready=1. If any pending: grant round-robin starting at rr pointer; send button i command; clear pending[i]; rr=i+1 mod NUM_BTN; -> CMD_WAIT (ready=0, busy=1).
- CMD_WAIT: on resp_rcvd -> IDLE, busy=0. On timeout: retry as in INIT_WAIT; when exhausted, err pulse, drop the command, -> IDLE.
- Pending latches: btn_rel[i] sets pending[i] in any state, including before init completes; requests are serviced after init. A repeat press while pending is coalesced. Set wins over clear when btn_rel[i] coincides with the grant of i.
- Timeout counter restarts on every send and on PROMPT entry. resp_rcvd in the same cycle as expiry counts as a response. resp_rcvd in PWRUP/IDLE/INIT_SEND is ignored.
- Latency: btn_rel in IDLE with nothing pending -> send two cycles later (latch, then grant).

Decomposition:
- Package bt_seq_pkg: state enum (PWRUP, PROMPT, INIT_SEND, INIT_WAIT, IDLE, CMD_WAIT) and a cmd_t struct {start, len}.
- Sub-module bt_req_arb: pending latches plus round-robin grant (req in, grant index/valid out, ack in).

Test Plan:
1. PWRUP_CYC=16: reset released -> cmd_n=1 for 16 cycles then 0; no send before a prompt resp_rcvd.
2. Prompt, then resp_rcvd after each send -> sends (0,6) then (6,10); ready=1 after the second response.
3. btn_rel=2'b11 in one IDLE cycle -> send (16,4), response, then send (20,4); next double press starts with button 0 (rr wrap).
4. TIMEOUT_CYC=64, MAX_RETRY=1, no response to (16,4) -> resend at +64 cycles, err pulse at +128, back to IDLE, busy=0.
5. Init timeout exhausted -> err pulse, cmd_n=1 again, sequence restarts from PWRUP.
6. btn_rel[0] during CMD_WAIT and again in the grant cycle -> command issued twice total, with no third.
